// File: rtl/decimal_entry_assembler_if.sv
// Decimal entry bus: command strobes from the front panel and the assembled operand.
interface decimal_entry_assembler_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 40
);
  logic [3:0]              i_digit;
  logic                    i_digit_pulse;
  logic                    i_backspace_pulse;
  logic                    i_sign_pulse;
  logic                    i_clear_pulse;
  logic [VALUE_W-1:0]      o_value;
  logic                    o_sign;
  logic                    o_valid;
  logic                    o_busy;
  logic [2:0]              o_digit_count;
  logic [4*NUM_DIGITS-1:0] o_bcd;
  logic                    o_err;

  modport master (
    output i_digit, i_digit_pulse, i_backspace_pulse, i_sign_pulse, i_clear_pulse,
    input  o_value, o_sign, o_valid, o_busy, o_digit_count, o_bcd, o_err
  );

  modport slave (
    input  i_digit, i_digit_pulse, i_backspace_pulse, i_sign_pulse, i_clear_pulse,
    output o_value, o_sign, o_valid, o_busy, o_digit_count, o_bcd, o_err
  );
endinterface

// File: rtl/decimal_entry_assembler.sv
// Builds a binary operand from decimal digits entered one at a time. A BCD shadow
// feeds the displays; an iterative multiply-by-10 loop produces the binary value.
// Optional macro ENTRY_AUTO_SHIFT_EN: a digit entered into a full entry drops the
// most significant digit instead of being rejected.
module decimal_entry_assembler #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 40
) (
  input logic                    i_clk,
  input logic                    i_reset,
  decimal_entry_assembler_if.slave bus
);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BcdW = 4 * NUM_DIGITS;

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  state_e              state_q, state_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [2:0]          count_q, count_d;
  logic [VALUE_W-1:0]  value_q, value_d;
  logic [VALUE_W-1:0]  acc_q, acc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                sign_q, sign_d;
  logic                err_q, err_d;
  logic                start;
  logic [3:0]          cur_digit;
  logic [VALUE_W-1:0]  acc_next;

  // One multiply-by-10 step, most significant digit first.
  assign cur_digit = bcd_q[idx_q*4 +: 4];
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + {{(VALUE_W-4){1'b0}}, cur_digit};

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      count_q <= '0;
      value_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      value_q <= value_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  // Command decode (clear > backspace > digit > sign) and conversion sequencing.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    value_d = value_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    err_d   = err_q;
    start   = 1'b0;

    if (bus.i_clear_pulse) begin
      state_d = StIdle;
      bcd_d   = '0;
      count_d = '0;
      value_d = '0;
      sign_d  = 1'b0;
      err_d   = 1'b0;
    end else if (state_q == StIdle) begin
      if (bus.i_backspace_pulse) begin
        err_d = 1'b0;
        if (count_q != 3'd0) begin
          bcd_d   = bcd_q >> 4;
          count_d = count_q - 3'd1;
          if (count_q == 3'd1) sign_d = 1'b0;
          start   = 1'b1;
        end
      end else if (bus.i_digit_pulse) begin
        if (bus.i_digit > 4'd9) begin
          err_d = 1'b1;
        end else if (count_q == 3'd0 && bus.i_digit == 4'd0) begin
          // Leading zero: accepted but changes nothing.
          err_d = 1'b0;
        end else if (count_q == 3'(NUM_DIGITS)) begin
`ifdef ENTRY_AUTO_SHIFT_EN
          bcd_d = {bcd_q[BcdW-5:0], bus.i_digit};
          err_d = 1'b0;
          start = 1'b1;
`else
          err_d = 1'b1;
`endif
        end else begin
          bcd_d   = {bcd_q[BcdW-5:0], bus.i_digit};
          count_d = count_q + 3'd1;
          err_d   = 1'b0;
          start   = 1'b1;
        end
      end else if (bus.i_sign_pulse) begin
        if (count_q != 3'd0) sign_d = ~sign_q;
      end

      if (start) begin
        state_d = StConvert;
        acc_d   = '0;
        idx_d   = IdxW'(NUM_DIGITS - 1);
      end
    end else begin
      acc_d = acc_next;
      idx_d = idx_q - 1'b1;
      if (idx_q == '0) begin
        value_d = acc_next;
        state_d = StIdle;
      end
    end
  end

  assign bus.o_value       = value_q;
  assign bus.o_sign        = sign_q;
  assign bus.o_busy        = (state_q == StConvert);
  assign bus.o_valid       = (state_q == StIdle);
  assign bus.o_digit_count = count_q;
  assign bus.o_bcd         = bcd_q;
  assign bus.o_err         = err_q;
endmodule
